text_cursor_writer: RTL and testbench

TEXT_CURSOR_WRITER -- requirements
Module: text_cursor_writer

---
 rtl/text_cursor_writer.sv | 103 ++++++++++
 tb/tb_text_cursor_writer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_cursor_writer.sv
// Cursor-driven writer for a 32x4 byte text buffer, fed one byte at a time from a UART receiver.
// Optional macro BACKSPACE_EN: 0x08 steps the cursor back one cell and blanks that cell.
module text_cursor_writer #(
  parameter logic [7:0] CLR_BYTE = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       we,
  output logic [4:0] w_row,
  output logic [1:0] w_col,
  output logic [7:0] din,
  output logic [4:0] cur_row,
  output logic [1:0] cur_col,
  output logic       busy
);

  // Handshake: a byte is taken on a rising edge where in_valid && in_ready. in_ready is a
  // registered output. It is high only in IDLE and drops in the cycle after a 0x0C is taken.
  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t     state;
  logic [6:0] clr_idx;
  logic [6:0] cur_lin;
  logic       accept;

  // Row-major cell index: incrementing it gives the col/row advance and the (31,3) -> (0,0) wrap.
  assign cur_lin = {cur_row, cur_col};
  assign accept  = in_valid && in_ready;

`ifdef BACKSPACE_EN
  logic [6:0] bs_lin;
  assign bs_lin = (cur_lin == 7'd0) ? 7'd0 : cur_lin - 7'd1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_CLEAR;
      clr_idx  <= 7'd0;
      cur_row  <= 5'd0;
      cur_col  <= 2'd0;
      we       <= 1'b0;
      w_row    <= 5'd0;
      w_col    <= 2'd0;
      din      <= 8'h00;
      in_ready <= 1'b0;
      busy     <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          we             <= 1'b1;
          {w_row, w_col} <= clr_idx;
          din            <= CLR_BYTE;
          clr_idx        <= clr_idx + 7'd1;
          in_ready       <= 1'b0;
          busy           <= 1'b1;
          // busy/in_ready stay put for the last write; IDLE releases them one edge later.
          if (clr_idx == 7'd127) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          we       <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
          if (accept) begin
            if (in_data == 8'h0C) begin
              state    <= ST_CLEAR;
              clr_idx  <= 7'd0;
              cur_row  <= 5'd0;
              cur_col  <= 2'd0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else if (in_data >= 8'h20) begin
              we                 <= 1'b1;
              {w_row, w_col}     <= cur_lin;
              din                <= in_data;
              {cur_row, cur_col} <= cur_lin + 7'd1;
            end else if (in_data == 8'h0D) begin
              cur_col <= 2'd0;
            end else if (in_data == 8'h0A) begin
              cur_row <= cur_row + 5'd1;
`ifdef BACKSPACE_EN
            end else if (in_data == 8'h08) begin
              we                 <= 1'b1;
              {w_row, w_col}     <= bs_lin;
              din                <= CLR_BYTE;
              {cur_row, cur_col} <= bs_lin;
`endif
            end
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_text_cursor_writer.sv
// Bench for text_cursor_writer: directed scenarios plus random byte streams checked against a
// linear-cursor reference model and an expected-write queue.
module tb_text_cursor_writer;

  localparam logic [7:0] CLR = 8'h00;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       we;
  logic [4:0] w_row;
  logic [1:0] w_col;
  logic [7:0] din;
  logic [4:0] cur_row;
  logic [1:0] cur_col;
  logic       busy;

  int tests = 0;
  int fails = 0;
  logic [14:0] exp_q[$];
  int mpos = 0;
  int wr_count = 0;
  logic [14:0] last_wr = '0;
  logic [14:0] got_wr;
  logic [14:0] exp_wr;

  text_cursor_writer #(.CLR_BYTE(CLR)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .we(we), .w_row(w_row), .w_col(w_col), .din(din), .cur_row(cur_row), .cur_col(cur_col),
    .busy(busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // scoreboard: every write strobe must match the head of the expected queue
  always @(posedge clk) begin
    #1;
    if (we === 1'b1) begin
      got_wr = {w_row, w_col, din};
      wr_count++;
      last_wr = got_wr;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL write_unexpected: got row %0d col %0d data %h, required no write",
                 w_row, w_col, din);
      end else begin
        exp_wr = exp_q.pop_front();
        if (got_wr !== exp_wr) begin
          fails++;
          $display("FAIL write_content: got row %0d col %0d data %h, required row %0d col %0d data %h",
                   w_row, w_col, din, exp_wr[14:10], exp_wr[9:8], exp_wr[7:0]);
        end
      end
    end
  end

  // reference model: cursor as a linear cell index 0..127
  task automatic model_clear();
    logic [6:0] a;
    for (int i = 0; i < 128; i++) begin
      a = 7'(i);
      exp_q.push_back({a, CLR});
    end
    mpos = 0;
  endtask

  task automatic model_accept(input logic [7:0] b);
    if (b == 8'h0C) begin
      model_clear();
    end else if (b >= 8'h20) begin
      exp_q.push_back({7'(mpos), b});
      mpos = (mpos + 1) % 128;
    end else if (b == 8'h0D) begin
      mpos = mpos - (mpos % 4);
    end else if (b == 8'h0A) begin
      mpos = (mpos + 4) % 128;
`ifdef BACKSPACE_EN
    end else if (b == 8'h08) begin
      if (mpos > 0) mpos = mpos - 1;
      exp_q.push_back({7'(mpos), CLR});
`endif
    end
  endtask

  // drivers (entered and left on a falling edge; in_valid stays high for back-to-back use)
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready %b after %0d cycles, required 1", in_ready, waited);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_accept(b);
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_clear();
    int cyc = 0;
    in_valid = 1'b0;
    while (busy !== 1'b0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL clear_timeout: busy %b after %0d cycles, required 0", busy, cyc);
    end
  endtask

  task automatic goto(input int row, input int col);
    send_byte(8'h0D);
    for (int k = 0; k < 32 && (mpos / 4) != row; k++) send_byte(8'h0A);
    repeat (col) send_byte(8'($urandom_range(32, 126)));
    idle(1);
  endtask

  task automatic test_reset();
    int n = 0;
    int cyc = 0;
    logic last_end = 1'b0;
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    exp_q.delete();
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    tests += 8;
    if (we !== 1'b0) begin fails++; $display("FAIL rst_we: got %b, required 0", we); end
    if (w_row !== 5'd0) begin fails++; $display("FAIL rst_w_row: got %0d, required 0", w_row); end
    if (w_col !== 2'd0) begin fails++; $display("FAIL rst_w_col: got %0d, required 0", w_col); end
    if (din !== 8'h00) begin fails++; $display("FAIL rst_din: got %h, required 00", din); end
    if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
    if (busy !== 1'b1) begin fails++; $display("FAIL rst_busy: got %b, required 1", busy); end
    if (cur_row !== 5'd0) begin fails++; $display("FAIL rst_cur_row: got %0d, required 0", cur_row); end
    if (cur_col !== 2'd0) begin fails++; $display("FAIL rst_cur_col: got %0d, required 0", cur_col); end
    while (busy !== 1'b0 && cyc < 300) begin
      if (we === 1'b1) n++;
      last_end = (we === 1'b1) && (w_row == 5'd31) && (w_col == 2'd3);
      @(negedge clk);
      cyc++;
    end
    tests += 5;
    if (n != 128) begin fails++; $display("FAIL sweep_count: got %0d writes, required 128", n); end
    if (cyc != 129) begin fails++; $display("FAIL sweep_length: got %0d cycles, required 129", cyc); end
    if (!last_end) begin fails++; $display("FAIL sweep_last: busy fall not right after (31,3) write"); end
    if (in_ready !== 1'b1) begin fails++; $display("FAIL sweep_ready: got %b, required 1", in_ready); end
    if (we !== 1'b0) begin fails++; $display("FAIL sweep_we_after: got %b, required 0", we); end
  endtask

  task automatic test_abcde();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h41 + i));
    idle(2);
    tests += 3;
    if (cur_row !== 5'd1 || cur_col !== 2'd1) begin
      fails++; $display("FAIL abcde_cursor: got (%0d,%0d), required (1,1)", cur_row, cur_col);
    end
    if (exp_q.size() != 0) begin fails++; $display("FAIL abcde_writes: %0d writes missing, required 0", exp_q.size()); end
    if (last_wr !== {7'd4, 8'h45}) begin fails++; $display("FAIL abcde_last: got %h, required %h", last_wr, {7'd4, 8'h45}); end
  endtask

  task automatic test_cr_lf();
    int base;
    goto(5, 2);
    tests++;
    if (cur_row !== 5'd5 || cur_col !== 2'd2) begin
      fails++; $display("FAIL crlf_setup: got (%0d,%0d), required (5,2)", cur_row, cur_col);
    end
    base = wr_count;
    send_byte(8'h0D);
    send_byte(8'h0A);
    send_byte(8'h5A);
    idle(3);
    tests += 3;
    if (wr_count - base != 1) begin fails++; $display("FAIL crlf_count: got %0d writes, required 1", wr_count - base); end
    if (last_wr !== {7'd24, 8'h5A}) begin fails++; $display("FAIL crlf_write: got %h, required %h", last_wr, {7'd24, 8'h5A}); end
    if (cur_row !== 5'd6 || cur_col !== 2'd1) begin
      fails++; $display("FAIL crlf_cursor: got (%0d,%0d), required (6,1)", cur_row, cur_col);
    end
  endtask

  task automatic test_wrap();
    int base;
    goto(31, 3);
    base = wr_count;
    send_byte(8'h51);
    idle(2);
    tests += 3;
    if (wr_count - base != 1) begin fails++; $display("FAIL wrap_count: got %0d writes, required 1", wr_count - base); end
    if (last_wr !== {7'd127, 8'h51}) begin fails++; $display("FAIL wrap_write: got %h, required %h", last_wr, {7'd127, 8'h51}); end
    if (cur_row !== 5'd0 || cur_col !== 2'd0) begin
      fails++; $display("FAIL wrap_cursor: got (%0d,%0d), required (0,0)", cur_row, cur_col);
    end
    goto(31, 0);
    send_byte(8'h0A);
    idle(2);
    tests++;
    if (cur_row !== 5'd0 || cur_col !== 2'd0) begin
      fails++; $display("FAIL lf_wrap: got (%0d,%0d), required (0,0)", cur_row, cur_col);
    end
  endtask

  task automatic test_backspace();
    int base;
    goto(2, 0);
    base = wr_count;
    send_byte(8'h08);
    idle(2);
    tests += 2;
`ifdef BACKSPACE_EN
    if (wr_count - base != 1 || last_wr !== {7'd7, CLR}) begin
      fails++; $display("FAIL bs_write: got %0d writes last %h, required 1 write %h", wr_count - base, last_wr, {7'd7, CLR});
    end
    if (cur_row !== 5'd1 || cur_col !== 2'd3) begin
      fails++; $display("FAIL bs_cursor: got (%0d,%0d), required (1,3)", cur_row, cur_col);
    end
    goto(0, 0);
    base = wr_count;
    send_byte(8'h08);
    idle(2);
    tests += 2;
    if (wr_count - base != 1 || last_wr !== {7'd0, CLR}) begin
      fails++; $display("FAIL bs_origin_write: got %0d writes last %h, required 1 write %h", wr_count - base, last_wr, {7'd0, CLR});
    end
    if (cur_row !== 5'd0 || cur_col !== 2'd0) begin
      fails++; $display("FAIL bs_origin_cursor: got (%0d,%0d), required (0,0)", cur_row, cur_col);
    end
`else
    if (wr_count - base != 0) begin fails++; $display("FAIL bs_write: got %0d writes, required 0", wr_count - base); end
    if (cur_row !== 5'd2 || cur_col !== 2'd0) begin
      fails++; $display("FAIL bs_cursor: got (%0d,%0d), required (2,0)", cur_row, cur_col);
    end
`endif
  endtask

  task automatic test_pending_clear();
    goto(3, 1);
    send_byte(8'h47);
    send_byte(8'h0C);
    wait_clear();
    idle(2);
    tests += 3;
    if (exp_q.size() != 0) begin fails++; $display("FAIL pend_writes: %0d writes missing, required 0", exp_q.size()); end
    if (cur_row !== 5'd0 || cur_col !== 2'd0) begin
      fails++; $display("FAIL pend_cursor: got (%0d,%0d), required (0,0)", cur_row, cur_col);
    end
    if (in_ready !== 1'b1) begin fails++; $display("FAIL pend_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_clear_reset();
    int n = 0;
    int cyc = 0;
    logic saw_ready = 1'b0;
    goto(4, 2);
    send_byte(8'h0C);
    in_valid = 1'b1;
    in_data  = 8'h41;
    while (n < 50 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (in_ready === 1'b1) saw_ready = 1'b1;
      if (we === 1'b1) n++;
    end
    tests++;
    if (n != 50) begin fails++; $display("FAIL midsweep_reach: got %0d writes, required 50", n); end
    reset = 1'b1;
    @(posedge clk);
    exp_q.delete();
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    cyc = 0;
    while (busy !== 1'b0 && cyc < 300) begin
      if (we === 1'b1) n++;
      if (in_ready === 1'b1) saw_ready = 1'b1;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    idle(2);
    tests += 4;
    if (n != 128) begin fails++; $display("FAIL restart_count: got %0d writes, required 128", n); end
    if (saw_ready) begin fails++; $display("FAIL sweep_ready_seen: in_ready rose during sweep, required 0"); end
    if (exp_q.size() != 0) begin fails++; $display("FAIL restart_writes: %0d writes missing, required 0", exp_q.size()); end
    if (cur_row !== 5'd0 || cur_col !== 2'd0) begin
      fails++; $display("FAIL restart_cursor: got (%0d,%0d), required (0,0)", cur_row, cur_col);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0: b = 8'h0D;
        1: b = 8'h0A;
        2: b = 8'h08;
        3: begin
          b = 8'($urandom_range(0, 31));
          if (b == 8'h0C) b = 8'h01;
        end
        default: b = 8'($urandom_range(32, 255));
      endcase
      send_byte(b);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      tests++;
      if (cur_row !== 5'(mpos / 4) || cur_col !== 2'(mpos % 4)) begin
        fails++;
        $display("FAIL rand_cursor: byte %h got (%0d,%0d), required (%0d,%0d)",
                 b, cur_row, cur_col, mpos / 4, mpos % 4);
      end
    end
    idle(3);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL rand_writes: %0d writes missing, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_abcde();
    test_cr_lf();
    test_wrap();
    test_backspace();
    test_pending_clear();
    test_clear_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
